// File: rtl/codificador_multidigito_if.sv
// Capture/display bus of the multi-digit code converter.
// The slave modport is the converter; the master modport is whoever drives the captures.
interface codificador_multidigito_if #(
  parameter int DIGITS = 4
);
  logic [3:0]        Input;
  logic              Ready;
  logic [1:0]        Mode;
  logic              Clear;
  logic [3:0]        Output;
  logic              Valid;
  logic              Error;
  logic [6:0]        Display;
  logic [DIGITS-1:0] DigitSel;

  modport master (
    output Input, Ready, Mode, Clear,
    input  Output, Valid, Error, Display, DigitSel
  );

  modport slave (
    input  Input, Ready, Mode, Clear,
    output Output, Valid, Error, Display, DigitSel
  );
endinterface

// File: rtl/codificador_multidigito.sv
// Multi-mode 4-bit code converter feeding a DIGITS-deep shift buffer that is
// time-multiplexed onto a single 7-segment bus with one-hot digit enables.
module codificador_multidigito #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input logic Clock,
  input logic Reset,
  codificador_multidigito_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'b00,
    MODE_XS3   = 2'b01,
    MODE_GRAY  = 2'b10,
    MODE_NINES = 2'b11
  } mode_e;

  typedef struct packed {
    logic       loaded;
    logic       err;
    logic [3:0] code;
  } entry_t;

  logic                    ready_q, ready_d;
  entry_t [DIGITS-1:0]     buf_q, buf_d;
  logic [3:0]              out_q, out_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PRE_W-1:0]        presc_q, presc_d;

  logic                    capture;
  logic [3:0]              conv_code;
  logic                    conv_err;
  entry_t                  cur;
  logic [DIGITS-1:0]       digit_sel;
  logic [6:0]              seg;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0: f = 7'b1111110;
      4'h1: f = 7'b0110000;
      4'h2: f = 7'b1101101;
      4'h3: f = 7'b1111001;
      4'h4: f = 7'b0110011;
      4'h5: f = 7'b1011011;
      4'h6: f = 7'b1011111;
      4'h7: f = 7'b1110000;
      4'h8: f = 7'b1111111;
      4'h9: f = 7'b1111011;
      4'hA: f = 7'b1110111;
      4'hB: f = 7'b0011111;
      4'hC: f = 7'b1001110;
      4'hD: f = 7'b0111101;
      4'hE: f = 7'b1001111;
      default: f = 7'b1000111;
    endcase
    return f;
  endfunction

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    conv_code = bus.Input;
    conv_err  = 1'b0;
    case (mode_e'(bus.Mode))
      MODE_BIN:   conv_code = bus.Input;
      MODE_XS3: begin
        if (bus.Input > 4'd9) begin
          conv_code = 4'd0;
          conv_err  = 1'b1;
        end else begin
          conv_code = bus.Input + 4'd3;
        end
      end
      MODE_GRAY:  conv_code = bus.Input ^ (bus.Input >> 1);
      MODE_NINES: begin
        if (bus.Input > 4'd9) begin
          conv_code = 4'd0;
          conv_err  = 1'b1;
        end else begin
          conv_code = 4'd9 - bus.Input;
        end
      end
      default:    conv_code = bus.Input;
    endcase
  end

  always_comb begin
    capture = bus.Ready & ~ready_q;
    ready_d = bus.Ready;
    buf_d   = buf_q;
    out_d   = out_q;
    err_d   = err_q;
    valid_d = 1'b0;

    // Clear wins over a coincident capture; the Ready edge is consumed either way.
    if (bus.Clear) begin
      buf_d = '0;
      out_d = 4'd0;
      err_d = 1'b0;
    end else if (capture) begin
      for (int k = DIGITS - 1; k > 0; k--) begin
        buf_d[k] = buf_q[k-1];
      end
      buf_d[0].loaded = 1'b1;
      buf_d[0].err    = conv_err;
      buf_d[0].code   = conv_code;
      out_d   = conv_code;
      err_d   = conv_err;
      valid_d = 1'b1;
    end

    presc_d = presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // NOTE: the digit buffer is a handful of flops, not a RAM, so it is reset
  // along with everything else; the blank-on-reset display depends on it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ready_q <= 1'b0;
      buf_q   <= '0;
      out_q   <= 4'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      presc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      ready_q <= ready_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
    end
  end

  // Enable and segments both come from the registered idx, so they never disagree.
  always_comb begin
    cur       = '0;
    digit_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur          = buf_q[i];
        digit_sel[i] = 1'b1;
      end
    end
    if (!cur.loaded) begin
      seg = 7'b0000000;
    end else if (cur.err) begin
      seg = 7'b0000001;
    end else begin
      seg = hex_font(cur.code);
    end
  end

  assign bus.Output   = out_q;
  assign bus.Error    = err_q;
  assign bus.Valid    = valid_q;
  assign bus.Display  = seg;
  assign bus.DigitSel = digit_sel;

endmodule

// File: tb/tb_codificador_multidigito.sv
// Bench for codificador_multidigito: directed scenarios plus random traffic,
// checked by a scoreboard against a queue-based reference model.
module tb_codificador_multidigito;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  codificador_multidigito_if #(.DIGITS(DIGITS)) bus ();

  codificador_multidigito #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit loaded;
    bit err;
    int code;
  } digit_t;

  typedef struct {
    int out;
    bit err;
  } resp_t;

  digit_t model_q[$];
  resp_t  sb_q[$];
  int     n_edges   = 0;
  bit     rd_prev   = 0;
  bit     started   = 0;
  int     exp_out   = 0;
  bit     exp_err   = 0;
  bit     exp_valid = 0;

  logic [6:0] font [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_conv(input int v, input int m, output int code, output bit err);
    err  = 0;
    code = 0;
    case (m)
      0: code = v;
      1: if (v > 9) err = 1; else code = v + 3;
      2: code = v ^ (v / 2);
      default: if (v > 9) err = 1; else code = 9 - v;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input digit_t d);
    if (!d.loaded) return 7'h00;
    if (d.err)     return 7'h01;
    return font[d.code];
  endfunction

  // Reference model: advances on the same edges the DUT sees.
  always @(posedge Clock) begin
    if (Reset) begin
      started   = 1;
      n_edges   = 0;
      model_q.delete();
      sb_q.delete();
      rd_prev   = 0;
      exp_out   = 0;
      exp_err   = 0;
      exp_valid = 0;
    end else if (started) begin
      n_edges++;
      exp_valid = 0;
      if (bus.Clear) begin
        model_q.delete();
        exp_out = 0;
        exp_err = 0;
      end else if (bus.Ready && !rd_prev) begin
        int     code;
        bit     err;
        digit_t d;
        resp_t  r;
        ref_conv(int'(bus.Input), int'(bus.Mode), code, err);
        exp_out   = code;
        exp_err   = err;
        exp_valid = 1;
        r.out = code;
        r.err = err;
        sb_q.push_back(r);
        d.loaded = 1;
        d.err    = err;
        d.code   = code;
        model_q.push_front(d);
        if (model_q.size() > DIGITS) void'(model_q.pop_back());
      end
      rd_prev = bus.Ready;
    end
  end

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge Clock) begin
    if (started) begin
      int idx;
      idx = (n_edges / SCAN_DIV) % DIGITS;
      check("digit_sel", bus.DigitSel, 32'(1) << idx);
      check("display", bus.Display, (idx < model_q.size()) ? seg_of(model_q[idx]) : 7'h00);
      check("valid", bus.Valid, exp_valid);
      check("output", bus.Output, exp_out);
      check("error", bus.Error, exp_err);
      if (bus.Valid) begin
        check("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          resp_t r;
          r = sb_q.pop_front();
          check("sb_output", bus.Output, r.out);
          check("sb_error", bus.Error, r.err);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic capture(input logic [3:0] v, input logic [1:0] m);
    bus.Input = v;
    bus.Mode  = m;
    bus.Ready = 1'b1;
    @(posedge Clock);
    #1;
    bus.Ready = 1'b0;
  endtask

  task automatic wait_sel(input logic [DIGITS-1:0] target);
    bit found;
    int tries;
    found = 0;
    tries = 0;
    while (!found && tries < 64) begin
      @(negedge Clock);
      tries++;
      if (bus.DigitSel === target) found = 1;
    end
    check("wait_sel", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.Input = 4'd0;
    bus.Mode  = 2'd0;
    bus.Ready = 1'b0;
    bus.Clear = 1'b0;
    Reset     = 1'b1;

    // Reset state and a full blank scan
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("rst_output", bus.Output, 0);
    check("rst_valid", bus.Valid, 0);
    check("rst_error", bus.Error, 0);
    check("rst_digitsel", bus.DigitSel, 4'b0001);
    repeat (DIGITS * SCAN_DIV) begin
      @(negedge Clock);
      check("rst_blank", bus.Display, 0);
    end

    // Excess-3 of 5, single-cycle Valid
    capture(4'd5, 2'b01);
    @(negedge Clock);
    check("xs3_output", bus.Output, 4'b1000);
    check("xs3_valid_hi", bus.Valid, 1);
    @(negedge Clock);
    check("xs3_valid_lo", bus.Valid, 0);
    wait_sel(4'b0001);
    check("xs3_digit0", bus.Display, 7'b1111111);
    wait_sel(4'b0010);
    check("xs3_digit1_blank", bus.Display, 0);

    // Gray code, then out-of-range Excess-3
    capture(4'b1011, 2'b10);
    @(negedge Clock);
    check("gray_output", bus.Output, 4'b1110);
    check("gray_error", bus.Error, 0);
    idle(1);
    capture(4'b1100, 2'b01);
    @(negedge Clock);
    check("oor_output", bus.Output, 0);
    check("oor_error", bus.Error, 1);
    wait_sel(4'b0001);
    check("oor_dash", bus.Display, 7'b0000001);

    // Ready held high: exactly one capture
    idle(1);
    bus.Input = 4'd7;
    bus.Mode  = 2'b00;
    bus.Ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge Clock);
      if (bus.Valid) cnt++;
    end
    bus.Ready = 1'b0;
    check("hold_one_valid", cnt, 1);

    // Overflow: 1..5 leaves 5,4,3,2
    idle(1);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      capture(4'(v), 2'b00);
      idle(1);
    end
    repeat (DIGITS * SCAN_DIV) begin
      logic [6:0] want;
      @(negedge Clock);
      case (bus.DigitSel)
        4'b0001: want = 7'h5B;
        4'b0010: want = 7'h33;
        4'b0100: want = 7'h79;
        default: want = 7'h6D;
      endcase
      check("overflow_font", bus.Display, want);
    end

    // Clear coinciding with a Ready rise: edge lost, digits blank
    @(negedge Clock);
    bus.Clear = 1'b1;
    bus.Ready = 1'b1;
    bus.Input = 4'd3;
    @(posedge Clock);
    #1 bus.Clear = 1'b0;
    @(negedge Clock);
    check("clr_valid", bus.Valid, 0);
    check("clr_output", bus.Output, 0);
    cnt = 0;
    repeat (3) begin
      @(negedge Clock);
      if (bus.Valid) cnt++;
    end
    check("clr_edge_lost", cnt, 0);
    bus.Ready = 1'b0;
    repeat (DIGITS * SCAN_DIV) begin
      @(negedge Clock);
      check("clr_blank", bus.Display, 0);
    end

    // Reset mid-scan at idx 2
    capture(4'd9, 2'b00);
    wait_sel(4'b0100);
    Reset = 1'b1;
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("midscan_digitsel", bus.DigitSel, 4'b0001);
    check("midscan_output", bus.Output, 0);

    // Ready high across reset release captures on the first free edge
    Reset     = 1'b1;
    bus.Ready = 1'b1;
    bus.Input = 4'd2;
    bus.Mode  = 2'b00;
    @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    check("rel_valid_lo", bus.Valid, 0);
    @(negedge Clock);
    check("rel_valid_hi", bus.Valid, 1);
    check("rel_output", bus.Output, 2);
    bus.Ready = 1'b0;
    idle(1);

    // Random traffic
    repeat (600) begin
      bus.Ready = 1'($urandom_range(0, 1));
      bus.Input = 4'($urandom);
      bus.Mode  = 2'($urandom);
      bus.Clear = ($urandom_range(0, 19) == 0);
      idle(1);
    end
    bus.Ready = 1'b0;
    bus.Clear = 1'b0;
    idle(4);
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codificador_multidigito.md
# codificador_multidigito

Parametrised multi-digit code converter with a multiplexed 7-segment display driver. Each rising edge of `Ready` captures one 4-bit input, converts it with the code selected by `Mode`, and shifts the result into a `DIGITS`-deep display buffer. A scan counter time-multiplexes the buffer onto one shared segment bus with one-hot digit enables. It is the clocked, multi-mode, multi-digit successor to the single-digit combinational encoder/display stage.

## Interface
- `DIGITS`, 4: number of buffered and displayed digits; must be ≥1.
- `SCAN_DIV`, 1000: clocks each digit stays selected; must be ≥1.

- `Clock`  in  1  single system clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Input`  in  4  raw value to encode.
- `Ready`  in  1  capture request, level signal; edge-detected internally.
- `Mode`  in  2  conversion select: 00 binary passthrough, 01 BCD→Excess-3, 10 binary→Gray, 11 BCD 9's complement.
- `Clear`  in  1  synchronous buffer clear.
- `Output`  out  4  last encoded value, registered.
- `Valid`  out  1  one-cycle pulse when `Output` is updated.
- `Error`  out  1  registered; set when the last capture was out of range.
- `Display`  out  7  segments a..g on bits 6..0, active-high.
- `DigitSel`  out  `DIGITS`  one-hot digit enable, active-high; bit 0 is the rightmost digit.

## Operation
- Edge detect: register `Ready_d`. A capture occurs at a clock edge where `Ready`=1 and `Ready_d`=0. Holding `Ready` high produces exactly one capture.
- Conversion, applied at capture using the `Mode` value sampled in that cycle:
  - 00: `Input`. Valid for 0–15.
  - 01: `Input`+3. Valid for 0–9.
  - 10: `Input` ^ (`Input`>>1). Valid for 0–15.
  - 11: 9−`Input`. Valid for 0–9.
- Out-of-range input in mode 01 or 11: `Output`=0, `Error`=1, and the stored digit is flagged as error.
- In-range capture: `Error`=0.
- Buffer: `DIGITS` entries, each holding {loaded, err, code[3:0]}. On capture, entry k takes entry k−1 and entry 0 takes the new value with loaded=1. The oldest entry is discarded once the buffer is full. There is no overflow flag.
- Changing `Mode` does not alter digits that are already stored.
- Segment font for entry[idx], combinational:
  - loaded=0 → 0000000 (blank).
  - err=1 → 0000001 (dash).
  - Otherwise hex: 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011, A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Scan:
  - Prescaler counts 0..`SCAN_DIV`−1.
  - At terminal count, the prescaler returns to 0 and `idx` advances, wrapping from `DIGITS`−1 to 0.
  - With `SCAN_DIV`=1, `idx` advances every clock.
  - `DIGITS`=1: `idx` stays 0.
  - `DigitSel` = onehot(`idx`). `Display` is decoded from the same registered `idx`, so the two are always coherent.
- Priority: `Reset` > `Clear` > capture.
  - `Clear` zeroes all buffer entries (loaded=0), `Output`, and `Error`, and suppresses `Valid`.
  - `Clear` does not reset the scan counter or the prescaler.
  - `Ready_d` still updates during `Clear`, so a `Ready` edge that coincides with `Clear` is lost, not deferred.

## Timing
- Reset values:
  - `Output`=0000, `Error`=0, `Valid`=0.
  - All buffer entries unloaded; `Ready_d`=0; `idx`=0; prescaler=0.
  - `DigitSel`=0…01, `Display`=0000000.
- Capture latency: with `Ready` seen high at edge n (low at n−1), `Output`, `Error`, and the buffer update at edge n. `Valid` is high from edge n until edge n+1.
- `Ready` asserted during or on the cycle `Reset` releases: `Ready_d` is 0 after reset, so `Ready` high at the first post-reset edge is a capture.
- Reset asserted mid-scan or mid-capture: all state returns to reset values on that edge, and no capture occurs.
- Back-to-back captures need `Ready` low for at least one sampled clock in between. The maximum capture rate is one every 2 clocks.

## Test plan
- Reset: assert `Reset` for 2 clocks → `Output`=0, `Valid`=0, `Error`=0, `DigitSel`=0001, `Display`=0000000 on every digit for a full scan.
- Mode 01, `Input`=5, one `Ready` pulse → next edge `Output`=1000 and `Valid` high for exactly 1 clock. Digit 0 shows 1111111; digits 1–3 are blank.
- Mode 10, `Input`=1011 → `Output`=1110, `Error`=0. Then mode 01, `Input`=1100 → `Output`=0000, `Error`=1, and digit 0 shows 0000001.
- `Ready` held high for 10 clocks with `Input`=7 in mode 00 → exactly one `Valid` pulse and one buffer shift.
- `DIGITS`=4, `SCAN_DIV`=2, mode 00, captures of 1,2,3,4,5 → entries 0..3 hold 5,4,3,2 (1 is dropped). `DigitSel` cycles 0001→0010→0100→1000→0001, with each value held for 2 clocks.
- `Clear` on the same edge as a `Ready` rise → all digits blank, `Valid`=0, `Output`=0, and scan `idx` unchanged. `Reset` mid-scan at `idx`=2 → `DigitSel`=0001 after that edge.
